// File: rtl/sw_arb_if.sv
// Bundle of the signals between the carb source, the engine return channels,
// the clause-queue write port and the switch that merges them.
interface sw_arb_if #(
    parameter int CLA_W   = 64,
    parameter int NUM_ENG = 4,
    parameter int SRC_W   = $clog2(NUM_ENG + 1)
);
    logic [CLA_W-1:0]         carb2sw;
    logic                     carb2sw_valid;
    logic                     sw2carb_stall;
    logic [NUM_ENG*CLA_W-1:0] eng2sw;
    logic [NUM_ENG-1:0]       eng2sw_valid;
    logic [NUM_ENG-1:0]       sw2eng_stall;
    logic [CLA_W-1:0]         sw2clq;
    logic                     sw2clq_valid;
    logic [SRC_W-1:0]         sw2clq_src;
    logic                     clq2sw_ready;

    // Environment side: drives the sources and the queue-ready, observes the switch.
    modport master (
        output carb2sw, carb2sw_valid, eng2sw, eng2sw_valid, clq2sw_ready,
        input  sw2carb_stall, sw2eng_stall, sw2clq, sw2clq_valid, sw2clq_src
    );

    // Switch side.
    modport slave (
        input  carb2sw, carb2sw_valid, eng2sw, eng2sw_valid, clq2sw_ready,
        output sw2carb_stall, sw2eng_stall, sw2clq, sw2clq_valid, sw2clq_src
    );
endinterface

// File: rtl/sw_arb.sv
// Clause switch: merges the carb stream and NUM_ENG engine return streams into
// the single clause-queue write port. Carb has priority, bounded by a streak
// limit so waiting engines always progress; engines share round-robin.
// The output is one registered stage that honours clause-queue backpressure.
module sw_arb #(
    parameter int CLA_W      = 64,
    parameter int NUM_ENG    = 4,
    parameter int STREAK_MAX = 8,
    parameter int SRC_W      = $clog2(NUM_ENG + 1)
) (
    input  logic    clk,
    input  logic    rst_n,
    sw_arb_if.slave bus
);
    localparam int PTR_W    = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;
    localparam int STREAK_W = $clog2(STREAK_MAX + 1);

    localparam logic [STREAK_W-1:0] STREAK_LIMIT = STREAK_W'(STREAK_MAX);
    localparam logic [PTR_W-1:0]    PTR_LAST     = PTR_W'(NUM_ENG - 1);
    localparam logic [PTR_W:0]      ENG_COUNT    = (PTR_W + 1)'(NUM_ENG);

    // Per-channel view of the packed engine data bus.
    logic [CLA_W-1:0] eng_data [NUM_ENG];

    for (genvar gi = 0; gi < NUM_ENG; gi++) begin : g_eng_unpack
        assign eng_data[gi] = bus.eng2sw[gi*CLA_W +: CLA_W];
    end

    logic [STREAK_W-1:0] streak_reg, streak_next;
    logic [PTR_W-1:0]    rr_ptr_reg, rr_ptr_next;
    logic [CLA_W-1:0]    out_data_reg, out_data_next;
    logic                out_valid_reg, out_valid_next;
    logic [SRC_W-1:0]    out_src_reg, out_src_next;

    logic               can_load;
    logic               eng_req;
    logic               eng_found;
    logic [PTR_W-1:0]   eng_sel;
    logic [PTR_W:0]     scan_sum;
    logic [PTR_W-1:0]   scan_idx;
    logic               carb_grant;
    logic [NUM_ENG-1:0] eng_grant;
    logic               any_grant;

    // Grant decision: carb first unless its streak has run out while an engine waits;
    // otherwise the first valid engine at or after the round-robin pointer.
    always_comb begin
        can_load   = !out_valid_reg || bus.clq2sw_ready;
        eng_req    = |bus.eng2sw_valid;
        eng_found  = 1'b0;
        eng_sel    = '0;
        scan_sum   = '0;
        scan_idx   = '0;
        carb_grant = 1'b0;
        eng_grant  = '0;

        for (int j = 0; j < NUM_ENG; j++) begin
            scan_sum = {1'b0, rr_ptr_reg} + (PTR_W + 1)'(j);
            if (scan_sum >= ENG_COUNT) begin
                scan_sum = scan_sum - ENG_COUNT;
            end
            scan_idx = scan_sum[PTR_W-1:0];
            if (!eng_found && bus.eng2sw_valid[scan_idx]) begin
                eng_found = 1'b1;
                eng_sel   = scan_idx;
            end
        end

        // Nothing is granted while in reset, so no source believes it transferred.
        if (rst_n && can_load) begin
            if (bus.carb2sw_valid && (!eng_req || streak_reg < STREAK_LIMIT)) begin
                carb_grant = 1'b1;
            end else if (eng_found) begin
                eng_grant[eng_sel] = 1'b1;
            end
        end
    end

    assign any_grant = carb_grant || (|eng_grant);

    // Stalls depend only on valids and arbitration state, never on clause data.
    assign bus.sw2carb_stall = rst_n & bus.carb2sw_valid & ~carb_grant;
    assign bus.sw2eng_stall  = {NUM_ENG{rst_n}} & bus.eng2sw_valid & ~eng_grant;

    // Next streak, round-robin pointer and output stage.
    always_comb begin
        streak_next    = streak_reg;
        rr_ptr_next    = rr_ptr_reg;
        out_data_next  = out_data_reg;
        out_valid_next = out_valid_reg;
        out_src_next   = out_src_reg;

        // The streak only counts carb wins that actually kept an engine waiting.
        if (!eng_req || (|eng_grant)) begin
            streak_next = '0;
        end else if (carb_grant && streak_reg != STREAK_LIMIT) begin
            streak_next = streak_reg + 1'b1;
        end

        if (|eng_grant) begin
            rr_ptr_next = (eng_sel == PTR_LAST) ? '0 : eng_sel + 1'b1;
        end

        if (carb_grant) begin
            out_data_next  = bus.carb2sw;
            out_src_next   = '0;
            out_valid_next = 1'b1;
        end else if (any_grant) begin
            out_data_next  = eng_data[eng_sel];
            out_src_next   = SRC_W'(eng_sel) + 1'b1;
            out_valid_next = 1'b1;
        end else if (bus.clq2sw_ready) begin
            out_valid_next = 1'b0;
        end
    end

    // State registers; reset drops any clause held in the output stage.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            streak_reg    <= '0;
            rr_ptr_reg    <= '0;
            out_data_reg  <= '0;
            out_valid_reg <= 1'b0;
            out_src_reg   <= '0;
        end else begin
            streak_reg    <= streak_next;
            rr_ptr_reg    <= rr_ptr_next;
            out_data_reg  <= out_data_next;
            out_valid_reg <= out_valid_next;
            out_src_reg   <= out_src_next;
        end
    end

    assign bus.sw2clq       = out_data_reg;
    assign bus.sw2clq_valid = out_valid_reg;
    assign bus.sw2clq_src   = out_src_reg;
endmodule

// File: tb/tb_sw_arb.sv
// Directed bench for sw_arb: each expected clause is queued on its grant cycle
// and compared against the registered output; stalls are checked every cycle.
module tb_sw_arb;
    localparam int CLA_W      = 64;
    localparam int NUM_ENG    = 4;
    localparam int STREAK_MAX = 8;
    localparam int SRC_W      = 3;

    typedef struct {
        logic [CLA_W-1:0] d;
        logic [SRC_W-1:0] s;
    } exp_t;

    logic clk;
    logic rst_n;
    int   tests_run;
    int   tests_failed;
    exp_t exp_q [$];

    sw_arb_if #(.CLA_W(CLA_W), .NUM_ENG(NUM_ENG), .SRC_W(SRC_W)) bus ();

    sw_arb #(
        .CLA_W(CLA_W), .NUM_ENG(NUM_ENG), .STREAK_MAX(STREAK_MAX), .SRC_W(SRC_W)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp)
        else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [CLA_W-1:0] d, input logic [SRC_W-1:0] s);
        exp_t e;
        e.d = d;
        e.s = s;
        exp_q.push_back(e);
    endtask

    // One clock: check combinational stalls, clock, then check the output stage.
    task automatic tick(input logic exp_cs, input logic [NUM_ENG-1:0] exp_es);
        logic pop;
        #1;
        chk("carb_stall", 64'(bus.sw2carb_stall), 64'(exp_cs));
        chk("eng_stall", 64'(bus.sw2eng_stall), 64'(exp_es));
        pop = bus.sw2clq_valid && bus.clq2sw_ready;
        @(posedge clk);
        #1;
        if (!rst_n) begin
            exp_q.delete();
        end else if (pop && exp_q.size() > 0) begin
            void'(exp_q.pop_front());
        end
        if (exp_q.size() > 0) begin
            chk("out_valid", 64'(bus.sw2clq_valid), 64'(1));
            chk("out_data", bus.sw2clq, exp_q[0].d);
            chk("out_src", 64'(bus.sw2clq_src), 64'(exp_q[0].s));
        end else begin
            chk("out_valid", 64'(bus.sw2clq_valid), 64'(0));
        end
        $display("[TB] t=%0t valid=%0b data=%0h src=%0d carb_stall=%0b eng_stall=%b",
                 $time, bus.sw2clq_valid, bus.sw2clq, bus.sw2clq_src,
                 bus.sw2carb_stall, bus.sw2eng_stall);
    endtask

    task automatic idle();
        bus.carb2sw_valid = 1'b0;
        bus.eng2sw_valid  = '0;
    endtask

    initial begin
        tests_run     = 0;
        tests_failed  = 0;
        rst_n         = 1'b0;
        bus.carb2sw       = 64'hA0;
        bus.carb2sw_valid = 1'b1;
        bus.eng2sw_valid  = 4'hF;
        bus.clq2sw_ready  = 1'b1;
        for (int i = 0; i < NUM_ENG; i++) begin
            bus.eng2sw[i*CLA_W +: CLA_W] = 64'(8'h10 + i);
        end

        // Reset with sources valid: nothing stalled, nothing granted.
        tick(1'b0, 4'b0000);
        tick(1'b0, 4'b0000);
        chk("rst_data", bus.sw2clq, 64'h0);
        chk("rst_src", 64'(bus.sw2clq_src), 64'h0);
        chk("rst_streak", 64'(dut.streak_reg), 64'h0);
        rst_n = 1'b1;
        idle();
        tick(1'b0, 4'b0000);

        // Carb only.
        for (int n = 1; n <= 3; n++) begin
            bus.carb2sw       = 64'(8'hA0 + n);
            bus.carb2sw_valid = 1'b1;
            push(64'(8'hA0 + n), 3'd0);
            tick(1'b0, 4'b0000);
        end
        idle();
        tick(1'b0, 4'b0000);

        // Engine round-robin with carb idle.
        bus.eng2sw_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            push(64'(8'h10 + (k % 4)), 3'((k % 4) + 1));
            tick(1'b0, 4'hF & ~(4'b0001 << (k % 4)));
        end
        idle();
        tick(1'b0, 4'b0000);

        // Starvation limit: eight carb wins, then engine 2, then carb again.
        bus.carb2sw_valid = 1'b1;
        bus.eng2sw_valid  = 4'b0100;
        for (int n = 0; n < STREAK_MAX; n++) begin
            bus.carb2sw = 64'(8'hC0 + n);
            push(64'(8'hC0 + n), 3'd0);
            tick(1'b0, 4'b0100);
        end
        chk("streak_full", 64'(dut.streak_reg), 64'(STREAK_MAX));
        bus.carb2sw = 64'hCF;
        push(64'h12, 3'd3);
        tick(1'b1, 4'b0000);
        chk("streak_clr", 64'(dut.streak_reg), 64'h0);
        push(64'hCF, 3'd0);
        tick(1'b0, 4'b0100);
        idle();
        tick(1'b0, 4'b0000);

        // Backpressure holds the output and stalls every source.
        bus.carb2sw       = 64'h55;
        bus.carb2sw_valid = 1'b1;
        push(64'h55, 3'd0);
        tick(1'b0, 4'b0000);
        bus.clq2sw_ready  = 1'b0;
        bus.carb2sw       = 64'h66;
        bus.eng2sw_valid  = 4'b0001;
        for (int n = 0; n < 5; n++) begin
            tick(1'b1, 4'b0001);
        end
        bus.clq2sw_ready = 1'b1;
        push(64'h66, 3'd0);
        tick(1'b0, 4'b0001);
        idle();
        tick(1'b0, 4'b0000);

        // Reset mid-stream with streak at 5 and a clause in the output stage.
        bus.carb2sw_valid = 1'b1;
        bus.eng2sw_valid  = 4'b1000;
        for (int n = 0; n < 5; n++) begin
            bus.carb2sw = 64'(8'hD0 + n);
            push(64'(8'hD0 + n), 3'd0);
            tick(1'b0, 4'b1000);
        end
        chk("streak_5", 64'(dut.streak_reg), 64'h5);
        rst_n = 1'b0;
        tick(1'b0, 4'b0000);
        chk("mid_rst_src", 64'(bus.sw2clq_src), 64'h0);
        chk("mid_rst_data", bus.sw2clq, 64'h0);
        rst_n = 1'b1;
        bus.carb2sw_valid = 1'b0;
        bus.eng2sw_valid  = 4'hF;
        push(64'h10, 3'd1);
        tick(1'b0, 4'b1110);
        push(64'h11, 3'd2);
        tick(1'b0, 4'b1101);
        idle();
        tick(1'b0, 4'b0000);

        // Pop-and-load: alternating carb / engine 1, no bubbles.
        for (int n = 0; n < 8; n++) begin
            if (n % 2 == 0) begin
                bus.carb2sw       = 64'(8'h70 + n);
                bus.carb2sw_valid = 1'b1;
                bus.eng2sw_valid  = 4'b0000;
                push(64'(8'h70 + n), 3'd0);
            end else begin
                bus.carb2sw_valid = 1'b0;
                bus.eng2sw_valid  = 4'b0010;
                push(64'h11, 3'd2);
            end
            tick(1'b0, 4'b0000);
        end
        idle();
        tick(1'b0, 4'b0000);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/sw_arb.md
Name: sw_arb

Overview:
- Parametrised successor of the clause switch.
- Merges one clause-arbiter (carb) stream and NUM_ENG engine return streams into the single clause-queue (clq) write port.
- Carb keeps priority, but a streak limit guarantees engine forward progress; engines are served round-robin among themselves.
- Output is registered (one pipeline stage) and honours clq backpressure.

Parameters:
- CLA_W, 64: clause word width in bits.
- NUM_ENG, 4: number of engine input channels (>=1).
- STREAK_MAX, 8: max consecutive carb grants while any engine is waiting (>=1).
- SRC_W, $clog2(NUM_ENG+1): width of the source id.

Ports:
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- carb2sw  in  CLA_W  clause from clause arbiter.
- carb2sw_valid  in  1  carb clause valid.
- sw2carb_stall  out  1  carb must hold its clause this cycle.
- eng2sw  in  NUM_ENG*CLA_W  engine clauses; channel i at [i*CLA_W +: CLA_W].
- eng2sw_valid  in  NUM_ENG  per-engine valid.
- sw2eng_stall  out  NUM_ENG  per-engine stall; engine holds data while stalled.
- sw2clq  out  CLA_W  registered clause to the clause queue.
- sw2clq_valid  out  1  registered output valid.
- sw2clq_src  out  SRC_W  source of sw2clq: 0 = carb, i+1 = engine i.
- clq2sw_ready  in  1  clause queue accepts (not full).

Behaviour:
- Transfer semantics: a source transfers in a cycle where its valid=1 and its stall=0.
- Output register can_load = !sw2clq_valid | clq2sw_ready. If can_load=0, all stalls equal their valids (nothing granted).
- Grant, evaluated when can_load=1. Let eng_req = |eng2sw_valid.
  - carb2sw_valid and (!eng_req or streak < STREAK_MAX): grant carb.
  - Else if eng_req: grant the first valid engine at or after rr_ptr (wrapping modulo NUM_ENG).
  - Else: no grant.
- Stall outputs:
  - sw2carb_stall = carb2sw_valid & !carb_grant.
  - sw2eng_stall[i] = eng2sw_valid[i] & !eng_grant[i].
  - Both are combinational from inputs and state; no combinational path from carb/eng data.
- State, streak counter ($clog2(STREAK_MAX+1) bits):
  - Carb grant while eng_req=1: streak+1, saturating at STREAK_MAX.
  - Any engine grant, or a cycle with eng_req=0: streak is cleared.
  - Otherwise: streak holds.
- State, rr_ptr:
  - On a grant to engine k, rr_ptr <= (k+1) mod NUM_ENG.
  - Otherwise rr_ptr holds.
- Output register:
  - On a grant: sw2clq <= granted data, sw2clq_src <= id, sw2clq_valid <= 1.
  - Else if clq2sw_ready: sw2clq_valid <= 0.
  - Else: hold all output fields.
- Latency: exactly 1 cycle from grant to sw2clq_valid. Full throughput of one clause/cycle with clq2sw_ready held high.
- Backpressure: with sw2clq_valid=1 and clq2sw_ready=0, output fields are stable and every source is stalled.
- Simultaneous pop-and-load: sw2clq_valid=1 with clq2sw_ready=1 and a new grant gives back-to-back valid with new data, no bubble.
- Reset (rst_n=0 at a clk edge, including mid-stream):
  - sw2clq_valid=0, sw2clq='0, sw2clq_src=0, streak=0, rr_ptr=0.
  - All stalls are 0 while in reset; any in-flight output clause is dropped.
- NUM_ENG=1, STREAK_MAX very large: degenerates to the legacy switch behaviour (carb priority, engine stalled when carb valid), plus the output register.

Test Plan:
- Carb only: carb2sw_valid=1 with data 0xA1, 0xA2, 0xA3 over 3 cycles, clq2sw_ready=1. Expect sw2clq 0xA1..0xA3 one cycle later each, src=0, sw2carb_stall=0 throughout.
- Engine round-robin (NUM_ENG=4, carb idle): all eng valid held with data 0x10+i. Expect grant order e0,e1,e2,e3,e0; src 1,2,3,4,1; each engine stalled except on its grant cycle.
- Starvation limit (STREAK_MAX=8): carb valid continuously and engine 2 valid continuously. Expect 8 carb grants, then one engine-2 grant (src=3), then carb resumes; streak reads 0 after the engine grant.
- Backpressure: output holds 0x55, clq2sw_ready=0 for 5 cycles, carb and eng0 valid. Expect sw2clq=0x55 stable, sw2clq_valid=1, sw2carb_stall=1, sw2eng_stall[0]=1. When ready returns, 0x55 pops and the carb clause loads the same cycle.
- Reset mid-stream: rst_n=0 for 1 cycle while sw2clq_valid=1 and streak=5. Next cycle expect sw2clq_valid=0, src=0, all stalls 0. After release, the first engine grant goes to e0.
- Pop-and-load: alternating carb/eng1 valid with ready=1. Expect sw2clq_valid never drops and data matches grant order.
